// File: rtl/program_sender.sv
// rtl/program_sender.sv - streams a program image from a synchronous ROM to a CPU UART bootloader
// Optional build macro PROGRAM_SENDER_TIMEOUT_EN bounds the wait for the final 0xAA acknowledge.
module program_sender #(
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] word_count,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [31:0]           rom_data,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_99,
    S_SEND_SIZE,
    S_FETCH,
    S_SEND_WORD,
    S_WAIT_AA,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [31:0]           shift_q, shift_d;

  logic [31:0]           size_field;
  logic                  last_word;
  logic                  rx_99;
  logic                  rx_aa;
  logic                  timeout_hit;

  assign size_field = 32'(count_q) << 2;
  assign last_word  = (word_idx_q == (count_q - ONE));
  assign rx_99      = rx_valid && (rx_data == 8'h99);
  assign rx_aa      = rx_valid && (rx_data == 8'hAA);

`ifdef PROGRAM_SENDER_TIMEOUT_EN
  logic [31:0] to_cnt_q, to_cnt_d;

  // Counter is held at zero outside WAIT_AA, so it restarts on every entry.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == S_WAIT_AA) begin
      to_cnt_d = to_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign timeout_hit = (to_cnt_q >= 32'(TIMEOUT_CYCLES - 1));
  assign error       = (state_q == S_ERROR);
`else
  assign timeout_hit = 1'b0;
  // Never true for a legal setting; ERROR is unreachable in this build.
  assign error       = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    addr_d     = addr_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_WAIT_99;
          count_d    = word_count;
          addr_d     = '0;
          word_idx_d = '0;
          byte_idx_d = '0;
        end
      end

      S_WAIT_99: begin
        if (rx_99) begin
          state_d    = S_SEND_SIZE;
          shift_d    = size_field;
          byte_idx_d = '0;
        end
      end

      S_SEND_SIZE: begin
        if (tx_ready) begin
          shift_d    = shift_q >> 8;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = (count_q == '0) ? S_WAIT_AA : S_FETCH;
          end
        end
      end

      // Address for this word has been stable for several cycles, so rom_data
      // is already valid here; step the address now so the next word is ready.
      S_FETCH: begin
        state_d    = S_SEND_WORD;
        shift_d    = rom_data;
        byte_idx_d = '0;
        if (!last_word) begin
          addr_d = addr_q + ONE;
        end
      end

      S_SEND_WORD: begin
        if (tx_ready) begin
          shift_d    = shift_q >> 8;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            if (last_word) begin
              state_d = S_WAIT_AA;
            end else begin
              state_d    = S_FETCH;
              word_idx_d = word_idx_q + ONE;
            end
          end
        end
      end

      S_WAIT_AA: begin
        if (rx_aa) begin
          state_d = S_DONE;
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end
      end

      S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      addr_q     <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
    end
  end

  assign rom_address = addr_q;
  assign tx_valid    = (state_q == S_SEND_SIZE) || (state_q == S_SEND_WORD);
  assign tx_data     = shift_q[7:0];
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_program_sender.sv
// tb/tb_program_sender.sv - table-driven and randomized checks of program_sender against a byte-stream model
`timescale 1ns/1ps
module tb_program_sender;
  localparam int AW = 12;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] word_count;
  logic [AW-1:0] rom_address;
  logic [31:0]   rom_data;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic          busy;
  logic          done;
  logic          error;

  logic [31:0] rom [0:(1<<AW)-1];
  byte unsigned exp_q[$];
  byte unsigned got_q[$];
  byte unsigned ref_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          wc;
    int          stall;
    bit          noise;
    int          rom_mode;
    logic [31:0] exp_size;
    int          exp_total;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_address];

  program_sender #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .word_count(word_count),
    .rom_address(rom_address), .rom_data(rom_data), .rx_valid(rx_valid),
    .rx_data(rx_data), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .done(done), .error(error)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected wire stream: byte count LSB first, then every word LSB first.
  task automatic build_model(input int wc);
    logic [31:0] sz;
    exp_q.delete();
    sz = wc * 4;
    for (int b = 0; b < 4; b++) exp_q.push_back(byte'((sz >> (8 * b)) & 32'hFF));
    for (int w = 0; w < wc; w++)
      for (int b = 0; b < 4; b++) exp_q.push_back(byte'((rom[w] >> (8 * b)) & 32'hFF));
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_stream(input int wc, input int stall, input bit noise, input int abort_at,
                             input int total, output int span);
    int          got;
    int          cyc;
    int          budget;
    int          first_c;
    int          last_c;
    bit          prev_stall;
    logic [7:0]  prev_td;
    logic        tv;
    logic [7:0]  td;
    bit          rdy;
    byte unsigned e;
    build_model(wc);
    got_q.delete();
    tx_ready   = 1'b0;
    word_count = wc[AW-1:0];
    start      = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    if (noise) begin
      send_rx(8'h55);
      check("no_tx_after_55", tx_valid, 0);
      send_rx(8'hAA);
      check("no_tx_after_aa", tx_valid, 0);
      check("busy_in_wait99", busy, 1);
    end
    repeat (2) tick();
    check("no_tx_before_99", tx_valid, 0);
    send_rx(8'h99);
    got = 0; cyc = 0; prev_stall = 0; prev_td = '0; first_c = -1; last_c = 0;
    budget = (5 * wc + 4) * ((stall > 0) ? 12 : 1) + 40;
    while (got < total && cyc < budget) begin
      if (abort_at > 0 && got == abort_at) break;
      tv = tx_valid;
      td = tx_data;
      if (prev_stall) begin
        check("hold_valid", tv, 1);
        check("hold_data", td, prev_td);
      end
      rdy      = ($urandom_range(99) >= stall);
      tx_ready = rdy;
      rx_valid = 1'b0;
      start    = 1'b0;
      if (noise && $urandom_range(3) == 0) begin
        rx_valid = 1'b1;
        rx_data  = ($urandom_range(1) == 1) ? 8'h99 : 8'hAA;
      end
      if (noise && $urandom_range(7) == 0) begin
        start      = 1'b1;
        word_count = AW'($urandom);
      end
      if (tv && rdy) begin
        e = exp_q.pop_front();
        check("tx_byte", td, e);
        got_q.push_back(td);
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        got++;
      end
      prev_stall = tv && !rdy;
      prev_td    = td;
      tick();
      cyc++;
    end
    rx_valid = 1'b0;
    start    = 1'b0;
    tx_ready = 1'b0;
    check("byte_count", got, (abort_at > 0) ? abort_at : total);
    span = last_c - first_c + 1;
  endtask

  task automatic finish_aa();
    check("wait_aa_no_tx", tx_valid, 0);
    check("wait_aa_busy", busy, 1);
    check("wait_aa_not_done", done, 0);
    send_rx(8'hAA);
    check("done_after_aa", done, 1);
    check("idle_busy_after_aa", busy, 0);
    word_count = 5;
    start      = 1'b1;
    tick();
    start = 1'b0;
    check("done_cleared", done, 0);
    check("busy_after_return", busy, 0);
    tick();
    check("no_relaunch", busy, 0);
  endtask

  task automatic check_size(input logic [31:0] exp_size);
    if (got_q.size() >= 4)
      check("size_field", {got_q[3], got_q[2], got_q[1], got_q[0]}, exp_size);
    else
      check("size_field_len", got_q.size(), 4);
  endtask

  initial begin
    int span;
    int wc;
    int st;
    byte unsigned golden[12];
    golden = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
               8'hDD, 8'hCC, 8'hBB, 8'hAA};
    vecs[0] = '{2,    0,  1'b0, 1, 32'd8,     12};
    vecs[1] = '{0,    0,  1'b0, 0, 32'd0,     4};
    vecs[2] = '{3,    50, 1'b0, 0, 32'd12,    16};
    vecs[3] = '{3,    0,  1'b1, 2, 32'd12,    16};
    vecs[4] = '{64,   30, 1'b1, 0, 32'd256,   260};
    vecs[5] = '{4095, 0,  1'b0, 0, 32'd16380, 16384};

    for (int i = 0; i < (1 << AW); i++) rom[i] = '0;
    reset_n = 1'b0; start = 1'b0; word_count = '0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    repeat (3) tick();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_rom_address", rom_address, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    reset_n = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].rom_mode == 1) begin
        rom[0] = 32'h11223344;
        rom[1] = 32'hAABBCCDD;
      end else if (vecs[v].rom_mode == 0) begin
        for (int w = 0; w < vecs[v].wc; w++) rom[w] = $urandom;
      end
      send_stream(vecs[v].wc, vecs[v].stall, vecs[v].noise, 0, vecs[v].exp_total, span);
      check_size(vecs[v].exp_size);
      if (vecs[v].stall == 0) check("throughput_span", span, 5 * vecs[v].wc + 4);
      if (v == 0)
        for (int b = 0; b < 12; b++)
          check("golden_byte", (b < got_q.size()) ? got_q[b] : 9'h100, golden[b]);
      if (v == 2) ref_q = got_q;
      if (v == 3) begin
        check("stall_stream_len", got_q.size(), ref_q.size());
        for (int b = 0; b < ref_q.size() && b < got_q.size(); b++)
          check("stall_stream_byte", got_q[b], ref_q[b]);
      end
      finish_aa();
    end

    for (int r = 0; r < 8; r++) begin
      wc = $urandom_range(1, 12);
      st = $urandom_range(0, 60);
      for (int w = 0; w < wc; w++) rom[w] = $urandom;
      send_stream(wc, st, 1'($urandom_range(1)), 0, 4 + 4 * wc, span);
      finish_aa();
    end

    for (int w = 0; w < 3; w++) rom[w] = $urandom;
    send_stream(3, 0, 1'b0, 6, 16, span);
    reset_n = 1'b0;
    #1;
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_rom_address", rom_address, 0);
    check("midrst_done", done, 0);
    tick();
    reset_n  = 1'b1;
    tx_ready = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h99;
    for (int c = 0; c < 5; c++) begin
      tick();
      rx_valid = 1'b0;
      check("postrst_no_tx", tx_valid, 0);
    end
    send_stream(3, 0, 1'b0, 0, 16, span);
    check_size(32'd12);
    finish_aa();

`ifdef PROGRAM_SENDER_TIMEOUT_EN
    begin
      int k;
      rom[0] = $urandom;
      send_stream(1, 0, 1'b0, 0, 8, span);
      k = 0;
      while (!error && k < 3 * TO) begin
        tick();
        k++;
      end
      check("timeout_cycles", k, TO);
      check("error_not_busy", busy, 0);
      check("error_not_done", done, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("error_cleared", error, 0);
      check("error_to_idle", busy, 0);
      tick();
      check("error_no_relaunch", busy, 0);
    end
`else
    rom[0] = $urandom;
    send_stream(1, 0, 1'b0, 0, 8, span);
    repeat (3 * TO) tick();
    check("no_timeout_error", error, 0);
    check("no_timeout_busy", busy, 1);
    finish_aa();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/program_sender.md
PROGRAM_SENDER -- requirements
Module: program_sender

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: width of program word address and word count.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: cycles allowed in WAIT_AA before error; used only when the timeout feature is compiled in.
REQ-003 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: one-cycle request to begin a download; honoured only in IDLE.
REQ-006 Port word_count, input, ADDR_WIDTH: number of 32-bit program words; sampled on an accepted start.
REQ-007 Port rom_address, output, ADDR_WIDTH: word address into the synchronous program source.
REQ-008 Port rom_data, input, 32: program word, valid exactly one cycle after rom_address changes.
REQ-009 Port rx_valid, input, 1: one-cycle strobe, a byte has arrived from the CPU UART.
REQ-010 Port rx_data, input, 8: received byte, valid with rx_valid.
REQ-011 Port tx_valid, output, 1: byte offered to the UART transmitter.
REQ-012 Port tx_data, output, 8: offered byte.
REQ-013 Port tx_ready, input, 1: transmitter accepts; a transfer occurs on a cycle with tx_valid and tx_ready both high.
REQ-014 Port busy, output, 1: high in every state except IDLE, DONE and ERROR.
REQ-015 Port done, output, 1: high while in DONE.
REQ-016 Port error, output, 1: high while in ERROR; tied low when the timeout feature is compiled out.

Function
REQ-017 States: IDLE, WAIT_99, SEND_SIZE, FETCH, SEND_WORD, WAIT_AA, DONE, ERROR.
- Transitions: IDLE -start-> WAIT_99. WAIT_99 -rx 0x99-> SEND_SIZE. SEND_SIZE -4th byte accepted-> FETCH, or WAIT_AA when count=0. FETCH -1 cycle-> SEND_WORD. SEND_WORD -4th byte accepted-> FETCH, or WAIT_AA after last word. WAIT_AA -rx 0xAA-> DONE.
REQ-018 In WAIT_99 and WAIT_AA, received bytes other than the awaited value are discarded, with no state change.
REQ-019 The size field is the byte count, word_count*4, sent as 32 bits zero-extended, least-significant byte first.
REQ-020 Each program word is sent as 4 bytes, bits [7:0] first and bits [31:24] last.
REQ-021 Words are sent in address order 0 to word_count-1.
REQ-022 rom_address is registered and is presented in FETCH.
- rom_data is latched into a 32-bit shift register on entry to SEND_WORD.
- The shift register is right-shifted by 8 bits on each accepted byte.
REQ-023 tx_valid is high only in SEND_SIZE and SEND_WORD.
- tx_data holds its value while tx_valid is high and tx_ready is low.
- tx_valid never drops before the byte is accepted.
REQ-024 Throughput: one byte per cycle while tx_ready is held high.
- A word costs 5 cycles: FETCH plus 4 bytes.
REQ-025 start is ignored outside IDLE.
- DONE and ERROR return to IDLE on start; start in that cycle does not also launch a new download.
REQ-026 rx_valid during SEND_SIZE, SEND_WORD or FETCH is ignored.
REQ-027 word_count equal to 2^ADDR_WIDTH-1 is the maximum supported value.
- The address counter does not wrap during a transfer.

Reset
REQ-028 Asserting reset_n low, including mid-transfer, forces IDLE immediately.
- All outputs go to 0: tx_valid, tx_data, rom_address, busy, done and error.
- The shift register and counters clear to 0.
REQ-029 After reset release, no byte is transmitted until a new start.

Configuration
REQ-030 Macro PROGRAM_SENDER_TIMEOUT_EN.
- When defined: a counter clears on entry to WAIT_AA and increments each cycle. If it reaches TIMEOUT_CYCLES before 0xAA arrives, the block enters ERROR.
- When undefined: no counter, ERROR is unreachable, error is constant 0, and WAIT_AA waits indefinitely.

Verification
REQ-031 word_count=2, ROM {0x11223344, 0xAABBCCDD}, tx_ready=1, rx sends 0x99 -> tx bytes 08 00 00 00 44 33 22 11 DD CC BB AA; then rx 0xAA -> done=1.
REQ-032 word_count=0, rx 0x99 -> tx bytes 00 00 00 00, then WAIT_AA; rx 0xAA -> done=1.
REQ-033 tx_ready toggled pseudo-randomly during a 3-word transfer -> tx_data stable while stalled; byte stream identical to the unstalled case.
REQ-034 rx 0x55, 0xAA, then 0x99 in WAIT_99 -> first two ignored; size transmission starts only after 0x99.
REQ-035 reset_n pulsed low after the 6th tx byte -> tx_valid=0 and busy=0 immediately; a new start with 0x99 restarts from the size field.
REQ-036 With PROGRAM_SENDER_TIMEOUT_EN, TIMEOUT_CYCLES=100, no 0xAA sent -> error=1 exactly 100 cycles after WAIT_AA entry; start then returns to IDLE.
